// File: rtl/mips32_fetch_queue.sv
// Instruction fetch queue ahead of decode: owns the PC, issues single-outstanding
// word reads, buffers {ir, npc} in order, flushes on redirect, halts after HLT.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                      clk1,
  input  logic                      rst_n,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_rvalid,
  input  logic [31:0]               imem_rdata,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      ir_valid,
  output logic [31:0]               ir,
  output logic [31:0]               npc,
  input  logic                      ir_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_npc;
  logic [31:0]       ir_q  [DEPTH];
  logic [ADDR_W-1:0] npc_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic              outstanding;
  logic              discard;
  logic              stopped;

  logic              resp_hlt;
  logic              room;
  logic              push;
  logic              pop;

  // A live response carrying HLT blocks the issue it would otherwise overlap with.
  assign resp_hlt = imem_rvalid && !discard && (imem_rdata[31:26] == 6'b111111);
  assign room     = (cnt + CNT_W'(outstanding)) < CNT_W'(DEPTH);
  assign imem_req = rst_n && !stopped && !redirect_valid &&
                    (!outstanding || imem_rvalid) && room && !resp_hlt;
  assign imem_addr = pc;

  assign push = imem_rvalid && !discard && !redirect_valid;
  assign pop  = ir_valid && ir_ready && !redirect_valid;

  assign ir_valid = (cnt != '0);
  assign ir       = ir_valid ? ir_q[head] : '0;
  assign npc      = ir_valid ? 32'(npc_q[head]) : '0;
  assign count    = cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= ADDR_W'(RESET_PC);
      req_npc     <= '0;
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      stopped     <= 1'b0;
    end else if (redirect_valid) begin
      pc      <= redirect_pc;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      stopped <= 1'b0;
      // A response landing now is consumed and dropped; otherwise the one in flight is marked stale.
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard <= 1'b1;
      end
    end else begin
      if (imem_req) begin
        pc          <= pc + 1'b1;
        req_npc     <= pc + 1'b1;
        outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end
      if (imem_rvalid && discard) discard <= 1'b0;
      if (push && resp_hlt)       stopped <= 1'b1;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (push) begin
      ir_q[tail]  <= imem_rdata;
      npc_q[tail] <= req_npc;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: program-order stream scoreboard with a latency-
// configurable memory, directed scenarios followed by randomized traffic.
module tb_mips32_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int AMOD   = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req, imem_rvalid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_valid, ir_ready;
  logic [31:0]       ir, npc;
  logic [2:0]        count;

  logic              imem_req2, imem_rvalid2, ir_valid2;
  logic [ADDR_W-1:0] imem_addr2;
  logic [31:0]       imem_rdata2, ir2, npc2;
  logic [2:0]        count2;

  mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(0)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir(ir), .npc(npc), .ir_ready(ir_ready), .count(count));

  mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(1022)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc('0),
    .ir_valid(ir_valid2), .ir(ir2), .npc(npc2), .ir_ready(1'b1), .count(count2));

  initial forever #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory image: Mem[k] = 0x1000_0000 + k, with an optional HLT word.
  int hlt_addr = -1;
  function automatic logic [31:0] mem_word(input int a);
    return (a == hlt_addr) ? 32'hFC00_0000 : 32'h1000_0000 + 32'(a);
  endfunction

  // Scoreboard: expected instructions in program order from the last restart point.
  typedef struct packed { logic [31:0] ir; logic [31:0] npc; } exp_t;
  exp_t sb_q[$];
  int   gen_addr = 0;
  bit   gen_done = 1'b0;
  bit   halted_seen = 1'b0;
  int   pop_cnt = 0;

  function automatic void refill();
    while (sb_q.size() < 8 && !gen_done) begin
      sb_q.push_back({mem_word(gen_addr), 32'((gen_addr + 1) % AMOD)});
      if (gen_addr == hlt_addr) gen_done = 1'b1;
      gen_addr = (gen_addr + 1) % AMOD;
    end
  endfunction

  function automatic void restart_stream(input int a);
    sb_q.delete();
    gen_addr    = a;
    gen_done    = 1'b0;
    halted_seen = 1'b0;
    refill();
  endfunction

  initial forever begin
    @(posedge clk1);
    refill();
  end

  // Memory model for the main DUT: one request in flight, fixed or random latency.
  int lat_fix = 1;
  bit rand_lat = 1'b0;
  bit pend = 1'b0;
  int rem = 0, paddr = 0;
  int req_cnt = 0, last_req_addr = -1;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk1);
      if (!rst_n) pend = 1'b0;
      else if (imem_req) begin
        pend = 1'b1;
        paddr = int'(imem_addr);
        rem = rand_lat ? int'($urandom_range(1, 3)) : lat_fix;
        req_cnt++;
        last_req_addr = int'(imem_addr);
      end
      @(posedge clk1);
      #1;
      imem_rvalid = 1'b0;
      if (rst_n && pend) begin
        rem--;
        if (rem == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend = 1'b0;
        end
      end
    end
  end

  // Second DUT: single-cycle memory, captures its first requests and outputs.
  bit r2_pend = 1'b0;
  int r2_addr = 0;
  bit cap2 = 1'b0;
  int a2_q[$];
  logic [63:0] p2_q[$];
  initial begin
    imem_rvalid2 = 1'b0;
    imem_rdata2  = '0;
    forever begin
      @(negedge clk1);
      r2_pend = rst_n && imem_req2;
      r2_addr = int'(imem_addr2);
      if (rst_n && cap2) begin
        if (imem_req2 && a2_q.size() < 3) a2_q.push_back(int'(imem_addr2));
        if (ir_valid2 && p2_q.size() < 3) p2_q.push_back({ir2, npc2});
      end
      @(posedge clk1);
      #1;
      imem_rvalid2 = r2_pend;
      imem_rdata2  = mem_word(r2_addr);
    end
  end

  // Monitor: every accepted head is compared against the scoreboard front.
  initial forever begin
    exp_t e;
    @(negedge clk1);
    if (rst_n) begin
      if (ir_valid && ir_ready && !redirect_valid) begin
        pop_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_pop actual_ir=%0h npc=%0h required=no_instruction", ir, npc);
        end else begin
          e = sb_q.pop_front();
          check("ir", 64'(ir), 64'(e.ir));
          check("npc", 64'(npc), 64'(e.npc));
          if (e.ir[31:26] == 6'b111111) halted_seen = 1'b1;
        end
      end else if (halted_seen && !redirect_valid) begin
        check("req_after_hlt", 64'(imem_req), 64'd0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    restart_stream(0);
    req_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    int p0;
    bit found;
    int tgt;
    bit prev_redir;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset state
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_ir_valid", 64'(ir_valid), 0);
    check("rst_ir", 64'(ir), 0);
    check("rst_npc", 64'(npc), 0);
    check("rst_imem_req", 64'(imem_req), 0);
    check("rst_count", 64'(count), 0);
    check("rst_imem_req2", 64'(imem_req2), 0);

    // Streaming with 1-cycle memory
    ir_ready = 1'b1;
    step();
    rst_n = 1'b1;
    restart_stream(0);
    cap2 = 1'b1;
    @(negedge clk1);
    check("c0_req", 64'(imem_req), 1);
    check("c0_addr", 64'(imem_addr), 0);
    @(negedge clk1);
    check("c1_ir_valid", 64'(ir_valid), 0);
    check("c1_addr", 64'(imem_addr), 1);
    @(negedge clk1);
    check("c2_ir_valid", 64'(ir_valid), 1);
    check("c2_addr", 64'(imem_addr), 2);
    p0 = pop_cnt;
    repeat (10) @(negedge clk1);
    check("throughput", 64'(pop_cnt - p0), 10);
    cap2 = 1'b0;
    check("r2_nreq", 64'(a2_q.size()), 3);
    check("r2_nout", 64'(p2_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      int a;
      a = (1022 + i) % AMOD;
      if (i < a2_q.size()) check("r2_addr", 64'(a2_q[i]), 64'(a));
      if (i < p2_q.size()) check("r2_out", p2_q[i], {mem_word(a), 32'((a + 1) % AMOD)});
    end

    // Backpressure: fill to DEPTH, then drain in order
    ir_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk1);
    @(negedge clk1);
    check("bp_count", 64'(count), DEPTH);
    check("bp_req", 64'(imem_req), 0);
    check("bp_nreq", 64'(req_cnt), DEPTH);
    step();
    ir_ready = 1'b1;
    @(negedge clk1);
    check("bp_req_pop_cycle", 64'(imem_req), 0);
    @(negedge clk1);
    check("bp_resume_req", 64'(imem_req), 1);
    check("bp_resume_addr", 64'(imem_addr), 4);
    repeat (8) @(negedge clk1);

    // Redirect while a 3-cycle response is outstanding
    lat_fix = 3;
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 10'd10;
    restart_stream(10);
    step();
    redirect_valid = 1'b0;
    @(negedge clk1);
    check("rd_count", 64'(count), 0);
    check("rd_ir_valid", 64'(ir_valid), 0);
    check("rd_req_while_stale", 64'(imem_req), 0);
    p0 = pop_cnt;
    repeat (16) @(negedge clk1);
    check("rd_progress", 64'(pop_cnt > p0), 1);

    // Redirect coinciding with push and pop at count 2
    lat_fix = 1;
    ir_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk1);
      #2;
      if (count == 3'd2 && imem_rvalid) found = 1'b1;
    end
    check("rpp_found", 64'(found), 1);
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd20;
    restart_stream(20);
    step();
    redirect_valid = 1'b0;
    @(negedge clk1);
    check("rpp_count", 64'(count), 0);
    check("rpp_ir_valid", 64'(ir_valid), 0);
    repeat (10) @(negedge clk1);

    // HLT at address 5, then restart by redirect
    hlt_addr = 5;
    do_reset();
    repeat (15) @(posedge clk1);
    @(negedge clk1);
    check("hlt_last_addr", 64'(last_req_addr), 5);
    check("hlt_nreq", 64'(req_cnt), 6);
    check("hlt_presented", 64'(halted_seen), 1);
    check("hlt_drained", 64'(count), 0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = '0;
    restart_stream(0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk1);
    check("hlt_restart_req", 64'(imem_req), 1);
    check("hlt_restart_addr", 64'(imem_addr), 0);
    repeat (15) @(negedge clk1);

    // Randomized traffic: variable latency, backpressure, redirects, HLT
    hlt_addr = int'($urandom_range(0, AMOD - 1));
    rand_lat = 1'b1;
    do_reset();
    prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      ir_ready = ($urandom_range(0, 3) != 0);
      if (!prev_redir && $urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       tgt = (hlt_addr - int'($urandom_range(0, 6)) + AMOD) % AMOD;
          1:       tgt = AMOD - 1 - int'($urandom_range(0, 3));
          default: tgt = int'($urandom_range(0, AMOD - 1));
        endcase
        redirect_valid = 1'b1;
        redirect_pc = ADDR_W'(tgt);
        restart_stream(tgt);
        prev_redir = 1'b1;
      end else begin
        redirect_valid = 1'b0;
        prev_redir = 1'b0;
      end
    end
    step();
    redirect_valid = 1'b0;
    ir_ready = 1'b1;
    repeat (20) @(negedge clk1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation_time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/mips32_fetch_queue.md
# mips32_fetch_queue

Instruction fetch queue that sits directly upstream of the decode stage of the 32-bit MIPS pipeline. It owns the program counter, issues word reads to instruction memory, buffers returned instructions with their next-PC, and presents them in order to decode under a valid/ready handshake. It flushes on a taken-branch redirect from EX/MEM and stops fetching after it fetches an HLT opcode (6'b111111).

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- ADDR_W, 10, instruction memory word-address width (1024 words)
- RESET_PC, 0, word address fetched first after reset

- clk1  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request; memory samples it on the clk1 edge
- imem_addr  out  ADDR_W  word address of the request
- imem_rvalid  in  1  response valid; asserted exactly once per accepted request, one or more cycles after the request
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1
- redirect_valid  in  1  taken branch; one-cycle pulse
- redirect_pc  in  ADDR_W  branch target word address
- ir_valid  out  1  queue head is valid
- ir  out  32  instruction at queue head
- npc  out  32  fetch address of head plus 1, zero-extended from ADDR_W bits
- ir_ready  in  1  decode accepts head when ir_valid && ir_ready
- count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- State: pc, circular queue of {ir, npc}, count, outstanding flag, discard flag, stopped flag.
- Issue rule (combinational): imem_req = !stopped && !redirect_valid && (!outstanding || imem_rvalid) && (count + outstanding) < DEPTH && !(imem_rvalid && !discard && imem_rdata[31:26]==6'b111111). imem_addr = pc.
- On an issue edge: pc <= pc+1, wrapping modulo 2^ADDR_W (1023 -> 0), and outstanding <= 1. A response with no new issue clears outstanding.
- Response with discard=0: push {imem_rdata, the address of that request + 1}. Response with discard=1: drop it and clear discard.
- A pushed word with opcode 6'b111111 sets stopped. No further requests are issued until redirect or reset. Entries already queued still drain.
- Pop on ir_valid && ir_ready. Push and pop may occur in the same cycle; count is then unchanged. The issue rule guarantees the queue never overflows. A pop on an empty queue cannot occur because ir_valid=0.
- Redirect has priority over every other event in its cycle:
  - queue emptied (count <= 0); any push or pop in that cycle is ignored;
  - pc <= redirect_pc; stopped <= 0; no request is issued;
  - if outstanding && !imem_rvalid, discard <= 1 and outstanding stays 1;
  - if imem_rvalid arrives in the redirect cycle, that response is dropped.
- ir_valid = (count != 0). ir and npc come from the head entry's registers, not from a memory path.

## Timing
- Reset (asynchronous, immediate):
  - pc=RESET_PC, count=0, outstanding=0, discard=0, stopped=0;
  - ir_valid=0, ir=0, npc=0, imem_req=0 while rst_n=0.
- With 1-cycle memory:
  - request in cycle n, response in n+1, ir_valid in n+2;
  - sustained throughput is 1 instruction/cycle when decode is always ready.
- Redirect in cycle r:
  - ir_valid=0 from r+1;
  - first request to redirect_pc in r+1 (or later if a discarded response is still pending);
  - its instruction is visible in r+3 with 1-cycle memory.
- Backpressure: with count+outstanding = DEPTH, imem_req stays 0 until a pop occurs; issue resumes in the cycle after that pop.
- Reset asserted mid-fetch: the pending response is not tracked. The memory model must not return stale data after reset.

## Test plan
- Reset, 1-cycle memory with Mem[k]=32'h1000_0000+k, ir_ready=1 -> imem_addr sequence 0,1,2,…; ir=32'h1000_0000 with npc=1 first valid 2 cycles after reset release, then one instruction per cycle.
- ir_ready=0, DEPTH=4 -> count reaches 4, imem_req held 0, exactly 4 requests issued; ir_ready=1 -> entries 0..3 pop in order, fetch resumes at address 4.
- Redirect pulse with redirect_pc=10 while a 3-cycle-latency response is outstanding -> count=0 next cycle, the stale response is dropped, the next ir is Mem[10] with npc=11.
- Redirect and push/pop in the same cycle at count=2 -> count=0 afterwards, no entry from before the redirect is ever presented.
- Mem[5]=32'hFC00_0000 (HLT) -> last request address 5, HLT presented with npc=6, no further imem_req; redirect to 0 -> fetching restarts at 0.
- RESET_PC=1022 -> addresses 1022,1023,0; npc of the instruction at 1023 equals 0.
